tmodel_seq: RTL and testbench
=============================

Name: tmodel_seq

Overview:
- Upstream sequencer for the Tmodel stage.
- Accepts one N-bit word over a valid/ready handshake and drives it as Tmodel's IN, held stable.
- Steps Tmodel's S1/S2 selects through all four modes, holding each mode for HOLD cycles.
- Captures Tmodel's OUT at the end of each mode and emits it downstream with a mode tag over a second valid/ready handshake.

Parameters:
- N, 98, data width of word, tm_in, tm_out, res_data (matches Tmodel N).
- HOLD, 10, settle cycles per mode before OUT is sampled; legal range ≥1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N  word to process.
- in_valid  input  1  in_data valid.
- in_ready  output  1  sequencer can accept a word.
- tm_in  output  N  to Tmodel IN; registered.
- tm_s1  output  1  to Tmodel S1; registered.
- tm_s2  output  1  to Tmodel S2; registered.
- tm_out  input  N  from Tmodel OUT.
- res_data  output  N  captured Tmodel OUT; registered.
- res_mode  output  2  {S2,S1} used for res_data.
- res_valid  output  1  result available.
- res_ready  input  1  downstream accepts result.
- busy  output  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; tm_in=0; tm_s1=0; tm_s2=0; res_data=0; res_mode=0; res_valid=0; cnt=0; mode=0.
  - in_valid is ignored while rst_n is low.
  - An assertion mid-operation aborts immediately; no partial result is emitted after release.
- Combinational outputs: in_ready = (state==IDLE); busy = (state≠IDLE).
- Mode order (index m → S1,S2): 0→(0,0), 1→(1,0), 2→(0,1), 3→(1,1). res_mode = {S2,S1} of the captured mode.
- States:
  - IDLE:
    - On in_valid & in_ready at edge k: tm_in←in_data, mode←0 (S1=S2=0), cnt←0, go SETTLE.
  - SETTLE:
    - cnt increments each cycle.
    - On the edge where cnt==HOLD-1: res_data←tm_out, res_mode←{S2,S1}, res_valid←1, go PRESENT.
    - First res_valid is therefore high from edge k+HOLD.
  - PRESENT:
    - res_data, res_mode, tm_in, S1 and S2 hold stable while res_valid & !res_ready (backpressure of any length).
    - On res_valid & res_ready:
      - res_valid←0.
      - If mode==3: go IDLE; in_ready is high the following cycle.
      - Otherwise: mode←mode+1, update S1/S2, cnt←0, go SETTLE.
- Per-word timing:
  - Exactly 4 results per accepted word, in mode order 0..3.
  - With res_ready tied high, a word occupies 4*(HOLD+1) cycles and back-to-back words are separated by one IDLE cycle.
- tm_in changes only at acceptance. S1/S2 change only on a PRESENT→SETTLE transition or at acceptance.
- HOLD=1: sample at the first edge after the mode is applied.
- cnt width: $clog2(HOLD+1), minimum 1 bit; no wrap during a legal sequence.
- in_valid asserted while busy: not accepted, no effect; in_data need not be held by the source until in_ready.
- res_ready asserted with res_valid low: ignored.

Optional Feature:
- Macro: TMODEL_SEQ_MASK_EN.
- Defined:
  - Adds port mode_mask input 4; bit m enables mode m.
  - mode_mask is latched at word acceptance.
  - Disabled modes are skipped entirely: no SETTLE, no result. The first state after acceptance is SETTLE of the lowest enabled mode.
  - PRESENT of the highest enabled mode returns to IDLE.
  - A latched mask of 4'b0000 is treated as 4'b1111.
- Undefined: port absent; all four modes always run.

Test Plan:
Bench stub for Tmodel: tm_out = tm_in + {tm_s2,tm_s1}; N=98, HOLD=10.
- Single word 4532, res_ready=1 → results 4532/4533/4534/4535 with res_mode 0/1/2/3; first res_valid at edge k+10, subsequent results every 11 cycles; in_ready high again 44 cycles after acceptance.
- Same word with res_ready low for 7 cycles during mode 1 → res_data=4533 and S1=1,S2=0 held stable all 7 cycles; mode 2 starts the cycle after the handshake; total 4 results, no duplicates.
- Two words 4532, 100 offered back-to-back with in_valid held → second accepted only after the 4th result of the first; outputs 4532..4535 then 100..103.
- rst_n pulsed low during mode 2 SETTLE → all outputs 0 asynchronously, in_ready=1 after release, no result for modes 2/3; a new word 7 produces 7..10.
- HOLD=1 build, word 0 → results 0,1,2,3, one every 2 cycles.
- TMODEL_SEQ_MASK_EN defined, word 4532, mask 4'b1010 → only results 4533 (mode 1) and 4535 (mode 3); mask 4'b0000 → all four results.

Source files
------------

// File: rtl/tmodel_seq.sv
// tmodel_seq: upstream sequencer for the Tmodel stage.
// Takes one word over a valid/ready handshake, holds it on tm_in, steps the
// S1/S2 selects through the four modes, lets each settle for HOLD cycles and
// forwards the sampled tm_out with its mode tag over a second handshake.
// Optional build macro: TMODEL_SEQ_MASK_EN adds a per-word mode_mask input.
module tmodel_seq #(
    parameter int unsigned N    = 98,
    parameter int unsigned HOLD = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
`ifdef TMODEL_SEQ_MASK_EN
    input  logic [3:0]   mode_mask,
`endif
    output logic [N-1:0] tm_in,
    output logic         tm_s1,
    output logic         tm_s2,
    input  logic [N-1:0] tm_out,
    output logic [N-1:0] res_data,
    output logic [1:0]   res_mode,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         busy
);

    localparam int unsigned CW = ($clog2(HOLD + 1) < 1) ? 1 : $clog2(HOLD + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    tm_in_q, tm_in_d;
    logic [1:0]      mode_q, mode_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    res_data_q, res_data_d;
    logic [1:0]      res_mode_q, res_mode_d;
    logic            res_valid_q, res_valid_d;

    logic [1:0]      first_mode;
    logic [1:0]      next_mode;
    logic            has_next;

`ifdef TMODEL_SEQ_MASK_EN
    logic [3:0]      mask_q, mask_d;
    logic [3:0]      accept_mask;
    logic            found;

    // Mode selection from the mask: lowest enabled mode at acceptance, next
    // higher enabled mode after each result; an all-zero mask means all modes.
    always_comb begin
        accept_mask = (mode_mask == 4'b0000) ? 4'b1111 : mode_mask;
        first_mode  = '0;
        found       = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (accept_mask[i] && !found) begin
                first_mode = 2'(i);
                found      = 1'b1;
            end
        end
        next_mode = mode_q;
        has_next  = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (mask_q[i] && (i > {30'd0, mode_q}) && !has_next) begin
                next_mode = 2'(i);
                has_next  = 1'b1;
            end
        end
    end
`else
    // Mode selection without a mask: always modes 0 through 3 in order.
    always_comb begin
        first_mode = '0;
        next_mode  = mode_q + 2'd1;
        has_next   = (mode_q != 2'd3);
    end
`endif

    // Next-state logic for the sequencer FSM and its datapath registers.
    always_comb begin
        state_d     = state_q;
        tm_in_d     = tm_in_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        res_data_d  = res_data_q;
        res_mode_d  = res_mode_q;
        res_valid_d = res_valid_q;
`ifdef TMODEL_SEQ_MASK_EN
        mask_d      = mask_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    tm_in_d = in_data;
                    mode_d  = first_mode;
                    cnt_d   = '0;
                    state_d = SETTLE;
`ifdef TMODEL_SEQ_MASK_EN
                    mask_d  = accept_mask;
`endif
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(HOLD - 1)) begin
                    res_data_d  = tm_out;
                    res_mode_d  = mode_q;
                    res_valid_d = 1'b1;
                    state_d     = PRESENT;
                end
            end
            PRESENT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (has_next) begin
                        mode_d  = next_mode;
                        cnt_d   = '0;
                        state_d = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tm_in_q     <= '0;
            mode_q      <= '0;
            cnt_q       <= '0;
            res_data_q  <= '0;
            res_mode_q  <= '0;
            res_valid_q <= 1'b0;
`ifdef TMODEL_SEQ_MASK_EN
            mask_q      <= '1;
`endif
        end else begin
            state_q     <= state_d;
            tm_in_q     <= tm_in_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            res_data_q  <= res_data_d;
            res_mode_q  <= res_mode_d;
            res_valid_q <= res_valid_d;
`ifdef TMODEL_SEQ_MASK_EN
            mask_q      <= mask_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign tm_in     = tm_in_q;
    assign tm_s1     = mode_q[0];
    assign tm_s2     = mode_q[1];
    assign res_data  = res_data_q;
    assign res_mode  = res_mode_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_tmodel_seq.sv
// Directed bench for tmodel_seq with a Tmodel stub (tm_out = tm_in + mode).
// A HOLD=10 instance carries most tests; a HOLD=1 instance covers the minimum.
module tb_tmodel_seq;

    localparam int unsigned N = 98;

    logic         clk = 1'b0;
    logic         rst_n;
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;

    // HOLD=10 instance
    logic [N-1:0] in_data, tm_in, tm_out, res_data;
    logic         in_valid, in_ready, tm_s1, tm_s2, res_valid, res_ready, busy;
    logic [1:0]   res_mode;
`ifdef TMODEL_SEQ_MASK_EN
    logic [3:0]   mode_mask;
`endif

    // HOLD=1 instance
    logic [N-1:0] in_data1, tm_in1, tm_out1, res_data1;
    logic         in_valid1, in_ready1, tm_s1_1, tm_s2_1, res_valid1, res_ready1, busy1;
    logic [1:0]   res_mode1;

    logic [N-1:0] rd_q[$];
    logic [1:0]   rm_q[$];
    int           rc_q[$];
    int           acc_q[$];
    logic [N-1:0] rd1_q[$];
    logic [1:0]   rm1_q[$];
    int           rc1_q[$];

    int           k;
    int           t;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign tm_out  = tm_in  + {96'd0, tm_s2,   tm_s1};
    assign tm_out1 = tm_in1 + {96'd0, tm_s2_1, tm_s1_1};

    tmodel_seq #(.N(N), .HOLD(10)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef TMODEL_SEQ_MASK_EN
        .mode_mask (mode_mask),
`endif
        .tm_in     (tm_in),
        .tm_s1     (tm_s1),
        .tm_s2     (tm_s2),
        .tm_out    (tm_out),
        .res_data  (res_data),
        .res_mode  (res_mode),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy)
    );

    tmodel_seq #(.N(N), .HOLD(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
`ifdef TMODEL_SEQ_MASK_EN
        .mode_mask (4'b0000),
`endif
        .tm_in     (tm_in1),
        .tm_s1     (tm_s1_1),
        .tm_s2     (tm_s2_1),
        .tm_out    (tm_out1),
        .res_data  (res_data1),
        .res_mode  (res_mode1),
        .res_valid (res_valid1),
        .res_ready (res_ready1),
        .busy      (busy1)
    );

    // Record handshakes that complete at the coming rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (res_valid && res_ready) begin
                rd_q.push_back(res_data);
                rm_q.push_back(res_mode);
                rc_q.push_back(cyc);
            end
            if (in_valid && in_ready) acc_q.push_back(cyc);
            if (res_valid1 && res_ready1) begin
                rd1_q.push_back(res_data1);
                rm1_q.push_back(res_mode1);
                rc1_q.push_back(cyc);
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        rd_q.delete();
        rm_q.delete();
        rc_q.delete();
        acc_q.delete();
    endtask

    // Offer one word for a single cycle; returns the acceptance edge index.
    task automatic offer(input logic [N-1:0] d, output int edge_k);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        edge_k   = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input int budget, input string tag);
        int w;
        w = 0;
        while (rd_q.size() < n && w < budget) begin
            tick();
            w++;
        end
        check(tag, rd_q.size(), n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        res_ready  = 1'b1;
        in_data1   = '0;
        in_valid1  = 1'b0;
        res_ready1 = 1'b1;
`ifdef TMODEL_SEQ_MASK_EN
        mode_mask  = 4'b1111;
`endif
        repeat (3) tick();

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_tm_in", tm_in, 0);
        check("rst_sel", {tm_s2, tm_s1}, 0);
        check("rst_res", {res_valid, res_mode, res_data}, 0);
        rst_n = 1'b1;
        tick();

        // Test 1: single word, res_ready high
        clear_q();
        offer(98'd4532, k);
        check("t1_tm_in", tm_in, 4532);
        check("t1_busy", {busy, in_ready}, 2'b10);
        check("t1_sel", {tm_s2, tm_s1}, 0);
        wait_results(4, 200, "t1_count");
        for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
            check("t1_data", rd_q[i], 4532 + i);
            check("t1_mode", rm_q[i], i);
            check("t1_time", rc_q[i] - k, 10 + 11 * i);
        end
        check("t1_idle_ready", in_ready, 1);
        check("t1_idle_at", cyc - k, 44);
        tick();

        // Test 2: backpressure for 7 cycles on the mode-1 result
        clear_q();
        offer(98'd4532, k);
        t = 0;
        while (!(res_valid && res_mode == 2'd1) && t < 100) begin
            tick();
            t++;
        end
        check("t2_reach_mode1", {res_valid, res_mode}, 3'b101);
        res_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("t2_hold_data", res_data, 4533);
            check("t2_hold_ctl", {res_valid, res_mode, tm_s2, tm_s1}, 5'b10101);
            check("t2_hold_in", tm_in, 4532);
        end
        res_ready = 1'b1;
        tick();
        check("t2_mode2_start", {res_valid, tm_s2, tm_s1}, 3'b010);
        wait_results(4, 200, "t2_count");
        tick();
        tick();
        check("t2_no_dup", rd_q.size(), 4);
        for (int i = 0; i < 4 && i < rd_q.size(); i++)
            check("t2_data", rd_q[i], 4532 + i);

        // Test 3: two words offered back-to-back with in_valid held
        clear_q();
        in_data  = 98'd4532;
        in_valid = 1'b1;
        t = 0;
        while (acc_q.size() < 1 && t < 20) begin tick(); t++; end
        in_data = 98'd100;
        t = 0;
        while (acc_q.size() < 2 && t < 200) begin tick(); t++; end
        in_valid = 1'b0;
        check("t3_accepts", acc_q.size(), 2);
        if (acc_q.size() == 2) check("t3_gap", acc_q[1] - acc_q[0], 45);
        wait_results(8, 200, "t3_count");
        for (int i = 0; i < 8 && i < rd_q.size(); i++)
            check("t3_data", rd_q[i], (i < 4) ? 4532 + i : 100 + i - 4);

        // Test 4: asynchronous reset during mode-2 settle
        tick();
        clear_q();
        offer(98'd4532, k);
        t = 0;
        while (!(tm_s2 && !tm_s1) && t < 100) begin tick(); t++; end
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_async_tm_in", tm_in, 0);
        check("t4_async_res", {res_valid, res_mode, res_data}, 0);
        check("t4_async_ctl", {busy, in_ready, tm_s2, tm_s1}, 4'b0100);
        in_data  = 98'd55;
        in_valid = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        check("t4_after_ready", {in_ready, busy}, 2'b10);
        repeat (60) tick();
        check("t4_partial_count", rd_q.size(), 2);
        clear_q();
        offer(98'd7, k);
        wait_results(4, 200, "t4_new_count");
        for (int i = 0; i < 4 && i < rd_q.size(); i++)
            check("t4_new_data", rd_q[i], 7 + i);
        tick();

        // Test 5: HOLD=1 instance, word 0
        in_data1  = '0;
        in_valid1 = 1'b1;
        tick();
        k = cyc;
        in_valid1 = 1'b0;
        t = 0;
        while (rd1_q.size() < 4 && t < 50) begin tick(); t++; end
        check("t5_count", rd1_q.size(), 4);
        for (int i = 0; i < 4 && i < rd1_q.size(); i++) begin
            check("t5_data", rd1_q[i], i);
            check("t5_mode", rm1_q[i], i);
            check("t5_time", rc1_q[i] - k, 1 + 2 * i);
        end

`ifdef TMODEL_SEQ_MASK_EN
        // Test 6: mask 1010 runs only modes 1 and 3; mask latched at acceptance
        tick();
        clear_q();
        mode_mask = 4'b1010;
        offer(98'd4532, k);
        mode_mask = 4'b1111;
        wait_results(2, 200, "t6_count");
        repeat (30) tick();
        check("t6_final_count", rd_q.size(), 2);
        if (rd_q.size() >= 2) begin
            check("t6_data0", rd_q[0], 4533);
            check("t6_mode0", rm_q[0], 1);
            check("t6_time0", rc_q[0] - k, 10);
            check("t6_data1", rd_q[1], 4535);
            check("t6_mode1", rm_q[1], 3);
            check("t6_time1", rc_q[1] - k, 21);
        end

        // Test 7: mask 0000 behaves as all modes
        clear_q();
        mode_mask = 4'b0000;
        offer(98'd4532, k);
        wait_results(4, 200, "t7_count");
        for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
            check("t7_data", rd_q[i], 4532 + i);
            check("t7_mode", rm_q[i], i);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
